// File: rtl/femto_uart_tx_pkg.sv
// Shared definitions for the femto UART transmitter: register map, STATUS layout,
// serial FSM encoding and the STATUS word packer.
package femto_uart_tx_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_TX_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd1;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_ACTIVE  = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_LVL_LSB = 8;
    localparam int STAT_LVL_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic                  full,
        input logic                  empty,
        input logic                  active,
        input logic                  ovf,
        input logic [STAT_LVL_W-1:0] level
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[STAT_FULL]   = full;
        s[STAT_EMPTY]  = empty;
        s[STAT_ACTIVE] = active;
        s[STAT_OVF]    = ovf;
        s[STAT_LVL_LSB +: STAT_LVL_W] = level;
        return s;
    endfunction

endpackage

// File: rtl/femto_uart_tx_if.sv
// CPU IO-window bus into the UART: decode hit, offset, store data and read/write strobes.
interface femto_uart_tx_if;
    import femto_uart_tx_pkg::*;

    logic              io_sel;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_wstrb;
    logic              io_rstrb;
    logic [DATA_W-1:0] io_rdata;

    modport master (output io_sel, io_addr, io_wdata, io_wstrb, io_rstrb, input io_rdata);
    modport slave  (input io_sel, io_addr, io_wdata, io_wstrb, io_rstrb, output io_rdata);

endinterface

// File: rtl/femto_uart_tx_fifo.sv
// TX byte FIFO with extra-MSB pointers; dout is the head entry, valid while !empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    // full/empty come from registered pointers, so a same-cycle pop never frees a slot for a push
    assign full    = (wptr_q ^ rptr_q) == {1'b1, {PW{1'b0}}};
    assign empty   = wptr_q == rptr_q;
    assign level   = wptr_q - rptr_q;
    assign dout    = mem[rptr_q[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/femto_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/overflow, FIFO and serial FSM.
module femto_uart_tx
    import femto_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    femto_uart_tx_if.slave bus,
    output logic           tx_busy,
    output logic           TXD
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    tx_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [7:0]        shreg_q;
    logic              txd_q, busy_q, ovf_q;
    logic [DATA_W-1:0] rdata_q;

    logic              wr_hit, rd_hit, stat_rd, drop, pop;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_dout;
    logic [PW:0]       fifo_level;
    logic [DATA_W-1:0] status;
    logic              unused_wdata;

    assign wr_hit  = bus.io_sel && bus.io_wstrb && (bus.io_addr == ADDR_TX_DATA);
    assign rd_hit  = bus.io_sel && bus.io_rstrb;
    assign stat_rd = rd_hit && (bus.io_addr == ADDR_STATUS);
    assign drop    = wr_hit && fifo_full;
    assign pop     = (state_q == ST_IDLE) && !fifo_empty;
    assign unused_wdata = ^bus.io_wdata[DATA_W-1:8];

    assign status = pack_status(fifo_full, fifo_empty, state_q != ST_IDLE, ovf_q,
                                STAT_LVL_W'(fifo_level));

    uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_hit && !fifo_full),
        .din   (bus.io_wdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // STATUS is sampled before the clear; a drop in the same cycle still leaves overflow set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= !fifo_empty || (state_q != ST_IDLE);
            if (rd_hit)  rdata_q <= stat_rd ? status : '0;
            if (stat_rd) ovf_q   <= 1'b0;
            if (drop)    ovf_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (!fifo_empty) begin
                        shreg_q <= fifo_dout;
                        bit_q   <= '0;
                        cnt_q   <= RELOAD;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= RELOAD;
                        txd_q   <= shreg_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= RELOAD;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            txd_q   <= shreg_q[1];
                            shreg_q <= {1'b0, shreg_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == '0) begin
                        txd_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.io_rdata = rdata_q;
    assign tx_busy      = busy_q;
    assign TXD          = txd_q;

endmodule
